// File: rtl/ram_stream_reader.sv
// Streams `length` consecutive words out of a single-port block RAM as a valid/ready stream.
// A 2-entry skid FIFO absorbs the RAM's registered read latency so backpressure never loses data.
module ram_stream_reader #(
    parameter int MEM_WIDTH = 8,
    parameter int MEM_SIZE  = 896
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(MEM_SIZE)-1:0]  base_addr,
    input  logic [$clog2(MEM_SIZE+1)-1:0] length,
    output logic                         busy,
    output logic                         done,
    output logic                         ram_en,
    output logic                         ram_we,
    output logic [$clog2(MEM_SIZE)-1:0]  ram_addr,
    input  logic [MEM_WIDTH-1:0]         ram_dout,
    output logic [MEM_WIDTH-1:0]         m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int LW = $clog2(MEM_SIZE+1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t                 state, state_nx;
    logic [AW-1:0]          addr;
    logic [LW-1:0]          len;
    logic [LW-1:0]          issue_cnt;
    logic [LW-1:0]          beat_cnt;
    logic                   pend;
    logic [MEM_WIDTH-1:0]   fifo [2];
    logic                   rd_ptr, wr_ptr;
    logic [1:0]             fifo_count;
    logic                   pop;
    logic                   issue;
    logic [2:0]             occ;

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo[rd_ptr];
    assign m_last  = m_valid && (beat_cnt == len - LW'(1));
    assign pop     = m_valid && m_ready;

    // Occupancy after this edge if nothing new is issued; a pop implies fifo_count >= 1.
    assign occ   = {1'b0, fifo_count} + {2'b00, pend} - {2'b00, pop};
    assign issue = (state == READ) && (issue_cnt < len) && (occ < 3'd2);

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        ram_en   = issue;
        ram_we   = 1'b0;
        ram_addr = addr;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (length == '0) ? FINISH : READ;
            end
            READ: begin
                busy = 1'b1;
                if (issue && (issue_cnt == len - LW'(1)))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && m_last)
                    state_nx = FINISH;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            len        <= '0;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
            pend       <= 1'b0;
            fifo[0]    <= '0;
            fifo[1]    <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                addr      <= base_addr;
                len       <= length;
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end
            if (issue) begin
                addr      <= (addr == AW'(MEM_SIZE-1)) ? '0 : addr + AW'(1);
                issue_cnt <= issue_cnt + LW'(1);
            end
            if (pop)
                beat_cnt <= beat_cnt + LW'(1);
            pend <= issue;
            // Data from last cycle's read lands now; capture it regardless of backpressure.
            if (pend) begin
                fifo[wr_ptr] <= ram_dout;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, pend} - {1'b0, pop};
        end
    end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Downstream read-out stage for the byte-wide single-port block RAM used for the input and output buffers.
- On a start pulse, reads `length` consecutive words from the RAM, beginning at `base_addr`.
- Hides the RAM's 1-cycle registered read latency behind a 2-entry skid FIFO.
- Presents the words as a valid/ready stream with full backpressure. Sustains 1 word/cycle while `m_ready` is held high.

Parameters:
- MEM_WIDTH, 8: RAM word width in bits; also the stream data width.
- MEM_SIZE, 896: RAM depth in words; used for address width and wrap-around.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  1-cycle request pulse; sampled only in IDLE.
- base_addr  in  $clog2(MEM_SIZE)  first RAM address; latched on accepted start.
- length  in  $clog2(MEM_SIZE+1)  number of words to stream; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until `done` is asserted.
- done  out  1  1-cycle completion pulse.
- ram_en  out  1  RAM enable; high only on cycles that issue a read.
- ram_we  out  1  held 0; this block never writes.
- ram_addr  out  $clog2(MEM_SIZE)  RAM read address.
- ram_dout  in  MEM_WIDTH  RAM registered read data; valid the cycle after `ram_en`.
- m_data  out  MEM_WIDTH  stream data (FIFO head).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the consumer.
- m_last  out  1  high with the final word of a transfer.

Behaviour:
- Reset (synchronous, highest priority, any state):
  - State returns to IDLE; FIFO and all counters are cleared; the pending-read flag is cleared.
  - Outputs: busy, done, ram_en, ram_we, m_valid and m_last are 0; ram_addr and m_data are 0.
  - A transfer in flight is abandoned with no `done` pulse.
- States: IDLE, READ, DRAIN, FINISH.
- IDLE:
  - start=1 with length≠0: latch base_addr and length, set issue_cnt=0 and beat_cnt=0, go to READ.
  - start=1 with length=0: go to FINISH directly; no RAM access occurs.
- Read issue, in READ:
  - Issue a read (ram_en=1, ram_addr=current address) when issue_cnt<length and fifo_count + pend − pop < 2.
  - `pend` = a read was issued last cycle. `pop` = m_valid & m_ready this cycle.
  - After each issue, the address increments. It wraps from MEM_SIZE−1 to 0.
  - When issue_cnt reaches length, go to DRAIN.
- Capture: when pend=1, push ram_dout into the FIFO at this clock edge. The FIFO never overflows by construction. Push and pop in the same cycle are both honoured.
- Stream output:
  - m_valid = fifo_count≠0; m_data = FIFO head.
  - A beat transfers on m_valid & m_ready; beat_cnt increments.
  - m_last = m_valid & (beat_cnt == length−1).
  - While m_valid=1 and m_ready=0, m_data must stay stable.
- DRAIN: no further issue. When the beat carrying m_last transfers, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, then return to IDLE.
- busy: 1 in READ and DRAIN, 0 in IDLE and FINISH.
- start while busy: ignored. start in FINISH: ignored; it is accepted only in the following IDLE cycle.
- Latency:
  - start sampled at edge E0.
  - First ram_en is in the cycle after E0.
  - RAM registers the data at E1.
  - FIFO captures at E2; m_valid=1 after E2, i.e. 2 cycles after start.
- Throughput: with m_ready held at 1, one beat per cycle. done follows 1 cycle after the last beat.
- Backpressure: at most 2 words are buffered plus 1 in flight. Reads stall cleanly and resume with no word lost or duplicated.

Test Plan:
- RAM preloaded with RAM[i]=i mod 256; base_addr=0, length=16, m_ready=1 → m_valid first high 2 cycles after start; data 0..15 on consecutive cycles; m_last with 15; done 1 cycle later.
- base_addr=890, length=10, MEM_SIZE=896 → ram_addr sequence 890..895, 0..3; data order matches; exactly 10 ram_en pulses.
- length=20, m_ready toggling pseudo-randomly (including 5-cycle stalls) → 20 beats with no loss or duplication; m_data stable while stalled; ram_en never issues when the FIFO plus in-flight count would exceed 2.
- length=0 → done 1 cycle after start; ram_en, m_valid and busy never asserted.
- start pulsed again mid-transfer → ignored, stream unchanged. rst asserted during beat 5 of 16 → next cycle all outputs 0 and state IDLE, no done pulse; a new start then streams correctly from its new base_addr.
- length=896, base_addr=0, m_ready=1 → full RAM streamed in 896 consecutive cycles; m_last on beat 895; ram_we stays 0 throughout.
